// File: rtl/csr_exec_unit.sv
// CSR execution stage: S1 packet register, S2 execute/writeback against the machine-mode CSR file.
// Optional macro CSR_COUNTERS_EN adds mcycle (0xB00) and minstret (0xB02).
module csr_exec_unit #(
  parameter int unsigned     PHY_W     = 8,
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] MTVEC_RST = 32'h0000_0100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [129:0]     issue_pkt,
  output logic [PHY_W-1:0] prf_raddr,
  input  logic [XLEN-1:0]  prf_rdata,
  input  logic             exception_sig,
  input  logic [XLEN-1:0]  exception_pc,
  input  logic [XLEN-1:0]  exception_cause,
  input  logic             mret_sig,
  output logic             CSR_done,
  output logic [PHY_W-1:0] CSR_phy,
  output logic [XLEN-1:0]  CSR_result,
  output logic [31:0]      CSR_inst_num,
  output logic             csr_illegal,
  output logic [XLEN-1:0]  csr_mepc,
  output logic [XLEN-1:0]  csr_mtvec
);

  typedef struct packed {
    logic [PHY_W-1:0] src;
    logic [31:0]      inst_num;
    logic [PHY_W-1:0] rd;
    logic [3:0]       aluop;
    logic             alusrc2;
    logic [11:0]      addr;
    logic [4:0]       zimm;
  } uop_t;

  uop_t            issue_uop, s1_uop, s2_uop;
  logic            s1_valid, s2_valid;
  logic [XLEN-1:0] s2_rdata;
  logic [XLEN-1:0] mstatus, mtvec, mscratch, mepc, mcause;
`ifdef CSR_COUNTERS_EN
  logic [XLEN-1:0] mcycle, minstret;
`endif
  logic            flush, fire, hit, wr_req, wr_en;
  logic [XLEN-1:0] old_val, src_val, wr_data;

  // csr_data and the upper immediate bits are not needed by this stage
  logic unused_pkt_bits;
  assign unused_pkt_bits = &{1'b0, issue_pkt[75:44], issue_pkt[31:5]};

  assign flush     = exception_sig | mret_sig;
  assign fire      = s2_valid & ~flush;
  assign prf_raddr = s1_uop.src;
  assign csr_mepc  = mepc;
  assign csr_mtvec = mtvec;

  always_comb begin
    issue_uop          = '0;
    issue_uop.src      = issue_pkt[128:121];
    issue_uop.inst_num = issue_pkt[120:89];
    issue_uop.rd       = issue_pkt[88:81];
    issue_uop.aluop    = issue_pkt[80:77];
    issue_uop.alusrc2  = issue_pkt[76];
    issue_uop.addr     = issue_pkt[43:32];
    issue_uop.zimm     = issue_pkt[4:0];
  end

  // S1/S2 pipeline registers; any flush kills both stages and the incoming packet
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_uop   <= '0;
      s2_valid <= 1'b0;
      s2_uop   <= '0;
      s2_rdata <= '0;
    end else begin
      s1_valid <= issue_pkt[129] & ~flush;
      if (issue_pkt[129]) s1_uop <= issue_uop;
      s2_valid <= s1_valid & ~flush;
      s2_uop   <= s1_uop;
      s2_rdata <= prf_rdata;
    end
  end

  // CSR read decode
  always_comb begin
    old_val = '0;
    hit     = 1'b1;
    case (s2_uop.addr)
      12'h300: old_val = mstatus;
      12'h305: old_val = mtvec;
      12'h340: old_val = mscratch;
      12'h341: old_val = mepc;
      12'h342: old_val = mcause;
`ifdef CSR_COUNTERS_EN
      12'hB00: old_val = mcycle;
      12'hB02: old_val = minstret;
`endif
      default: hit = 1'b0;
    endcase
  end

  assign src_val = s2_uop.alusrc2 ? XLEN'(s2_uop.zimm) : s2_rdata;

  // RS/RC with a zero mask never write
  always_comb begin
    wr_req  = 1'b0;
    wr_data = old_val;
    case (s2_uop.aluop)
      4'h1: begin wr_req = 1'b1;       wr_data = src_val;            end
      4'h2: begin wr_req = |src_val;   wr_data = old_val | src_val;  end
      4'h3: begin wr_req = |src_val;   wr_data = old_val & ~src_val; end
      default: ;
    endcase
  end

  assign wr_en = fire & hit & wr_req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      CSR_done     <= 1'b0;
      csr_illegal  <= 1'b0;
      CSR_phy      <= '0;
      CSR_result   <= '0;
      CSR_inst_num <= '0;
    end else begin
      CSR_done    <= fire;
      csr_illegal <= fire & ~hit;
      if (fire) begin
        CSR_phy      <= s2_uop.rd;
        CSR_result   <= old_val;
        CSR_inst_num <= s2_uop.inst_num;
      end
    end
  end

  // CSR file; later assignments win, so trap state overrides and writes override counting
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mstatus  <= '0;
      mtvec    <= MTVEC_RST;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
`ifdef CSR_COUNTERS_EN
      mcycle   <= '0;
      minstret <= '0;
`endif
    end else begin
`ifdef CSR_COUNTERS_EN
      mcycle <= mcycle + XLEN'(1);
      if (fire) minstret <= minstret + XLEN'(1);
`endif
      if (wr_en) begin
        case (s2_uop.addr)
          12'h300: mstatus  <= wr_data;
          12'h305: mtvec    <= wr_data;
          12'h340: mscratch <= wr_data;
          12'h341: mepc     <= {wr_data[XLEN-1:2], 2'b00};
          12'h342: mcause   <= wr_data;
`ifdef CSR_COUNTERS_EN
          12'hB00: mcycle   <= wr_data;
          12'hB02: minstret <= wr_data;
`endif
          default: ;
        endcase
      end
      if (exception_sig) begin
        mepc   <= exception_pc;
        mcause <= exception_cause;
      end
    end
  end

endmodule

// File: tb/tb_csr_exec_unit.sv
// Self-checking bench for csr_exec_unit: directed scenarios then random traffic against a queue-based model.
module tb_csr_exec_unit;

  logic         clk = 1'b0;
  logic         reset;
  logic [129:0] issue_pkt;
  logic [7:0]   prf_raddr;
  logic [31:0]  prf_rdata;
  logic         exception_sig;
  logic [31:0]  exception_pc;
  logic [31:0]  exception_cause;
  logic         mret_sig;
  logic         CSR_done;
  logic [7:0]   CSR_phy;
  logic [31:0]  CSR_result;
  logic [31:0]  CSR_inst_num;
  logic         csr_illegal;
  logic [31:0]  csr_mepc;
  logic [31:0]  csr_mtvec;

  csr_exec_unit dut (
    .clk(clk), .reset(reset), .issue_pkt(issue_pkt),
    .prf_raddr(prf_raddr), .prf_rdata(prf_rdata),
    .exception_sig(exception_sig), .exception_pc(exception_pc),
    .exception_cause(exception_cause), .mret_sig(mret_sig),
    .CSR_done(CSR_done), .CSR_phy(CSR_phy), .CSR_result(CSR_result),
    .CSR_inst_num(CSR_inst_num), .csr_illegal(csr_illegal),
    .csr_mepc(csr_mepc), .csr_mtvec(csr_mtvec)
  );

  always #5 clk = ~clk;

  logic [31:0] prf_mem [256];
  assign prf_rdata = prf_mem[prf_raddr];

  typedef struct {
    logic [7:0]  src;
    logic [31:0] inst;
    logic [7:0]  rd;
    logic [3:0]  op;
    logic        isrc;
    logic [11:0] addr;
    logic [31:0] imm;
    int          edge_no;
  } pkt_t;

  pkt_t        inflight[$];
  logic [31:0] csr_m [logic [11:0]];
  int          edge_no = 0;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_no);
    end
  endtask

  task automatic model_reset();
    inflight.delete();
    csr_m.delete();
    csr_m[12'h300] = 32'h0;
    csr_m[12'h305] = 32'h0000_0100;
    csr_m[12'h340] = 32'h0;
    csr_m[12'h341] = 32'h0;
    csr_m[12'h342] = 32'h0;
  endtask

  function automatic pkt_t mk(input logic [7:0] src, input logic [7:0] rd, input logic [3:0] op,
                              input logic isrc, input logic [11:0] addr, input logic [31:0] imm,
                              input logic [31:0] inst);
    pkt_t p;
    p.src = src; p.rd = rd; p.op = op; p.isrc = isrc;
    p.addr = addr; p.imm = imm; p.inst = inst; p.edge_no = 0;
    return p;
  endfunction

  // One clock: drive at negedge, sample 1ns after posedge, advance the model and compare
  task automatic step(input logic v, input pkt_t p, input logic exc, input logic [31:0] pc,
                      input logic [31:0] cause, input logic mret);
    logic        flush, exp_done, exp_ill, wr;
    logic [31:0] srcv, oldv, newv, junk;
    logic [7:0]  exp_phy;
    logic [31:0] exp_inst;
    pkt_t        x;
    @(negedge clk);
    junk = $urandom;
    issue_pkt = v ? {1'b1, p.src, p.inst, p.rd, p.op, p.isrc, junk, p.addr, p.imm}
                  : {1'b0, 129'($urandom)};
    exception_sig = exc; exception_pc = pc; exception_cause = cause; mret_sig = mret;
    @(posedge clk);
    #1;
    edge_no++;
    flush = exc | mret;
    exp_done = 1'b0; exp_ill = 1'b0; oldv = '0; exp_phy = '0; exp_inst = '0;
    if (inflight.size() > 0 && inflight[0].edge_no == edge_no - 2 && !flush) begin
      x = inflight.pop_front();
      srcv = x.isrc ? {27'b0, x.imm[4:0]} : prf_mem[x.src];
      if (csr_m.exists(x.addr)) oldv = csr_m[x.addr];
      else exp_ill = 1'b1;
      wr = 1'b0; newv = oldv;
      case (x.op)
        4'h1: begin wr = 1'b1; newv = srcv; end
        4'h2: begin wr = (srcv != 0); newv = oldv | srcv; end
        4'h3: begin wr = (srcv != 0); newv = oldv & ~srcv; end
        default: ;
      endcase
      if (wr && !exp_ill) csr_m[x.addr] = (x.addr == 12'h341) ? (newv & ~32'h3) : newv;
      exp_done = 1'b1; exp_phy = x.rd; exp_inst = x.inst;
    end
    if (exc) begin
      csr_m[12'h341] = pc;
      csr_m[12'h342] = cause;
    end
    if (flush) inflight.delete();
    else if (v) begin
      p.edge_no = edge_no;
      inflight.push_back(p);
    end
    check("done", 32'(CSR_done), 32'(exp_done));
    check("illegal", 32'(csr_illegal), 32'(exp_ill));
    if (exp_done) begin
      check("phy", 32'(CSR_phy), 32'(exp_phy));
      check("result", CSR_result, oldv);
      check("inst_num", CSR_inst_num, exp_inst);
    end
    check("mepc", csr_mepc, csr_m[12'h341]);
    check("mtvec", csr_mtvec, csr_m[12'h305]);
    if (inflight.size() > 0 && inflight[$].edge_no == edge_no)
      check("prf_raddr", 32'(prf_raddr), 32'(inflight[$].src));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, mk(0, 0, 0, 0, 0, 0, 0), 1'b0, 0, 0, 1'b0);
  endtask

  task automatic issue(input pkt_t p);
    step(1'b1, p, 1'b0, 0, 0, 1'b0);
  endtask

  logic [11:0] addrs [7];

  initial begin
    addrs = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h7C0, 12'hB00};
    for (int i = 0; i < 256; i++) prf_mem[i] = $urandom;
    prf_mem[5] = 32'hDEAD_BEEF;
    prf_mem[7] = 32'h0000_1237;
    issue_pkt = '0; exception_sig = 1'b0; exception_pc = '0; exception_cause = '0; mret_sig = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    model_reset();
    #10;
    check("rst_done", 32'(CSR_done), 32'h0);
    check("rst_illegal", 32'(csr_illegal), 32'h0);
    check("rst_phy", 32'(CSR_phy), 32'h0);
    check("rst_result", CSR_result, 32'h0);
    check("rst_inst", CSR_inst_num, 32'h0);
    check("rst_raddr", 32'(prf_raddr), 32'h0);
    check("rst_mepc", csr_mepc, 32'h0);
    check("rst_mtvec", csr_mtvec, 32'h0000_0100);
    reset = 1'b1;

    // RW mscratch from PRF, then read it back with RS imm 0
    issue(mk(8'd5, 8'd9, 4'h1, 1'b0, 12'h340, 32'h0, 32'd1));
    idle(2);
    check("rw_done", 32'(CSR_done), 32'h1);
    check("rw_phy", 32'(CSR_phy), 32'd9);
    check("rw_old", CSR_result, 32'h0);
    issue(mk(8'd0, 8'd10, 4'h2, 1'b1, 12'h340, 32'h0, 32'd2));
    idle(2);
    check("rs0_read", CSR_result, 32'hDEAD_BEEF);

    // back-to-back RSI then RCI on mstatus
    issue(mk(8'd0, 8'd11, 4'h2, 1'b1, 12'h300, 32'h0F, 32'd3));
    issue(mk(8'd0, 8'd12, 4'h3, 1'b1, 12'h300, 32'h03, 32'd4));
    idle(1);
    check("rsi_old", CSR_result, 32'h0);
    idle(1);
    check("rci_old", CSR_result, 32'h0F);
    issue(mk(8'd0, 8'd13, 4'h2, 1'b1, 12'h300, 32'h0, 32'd5));
    idle(2);
    check("mstatus_end", CSR_result, 32'h0C);

    // unimplemented CSR
    issue(mk(8'd5, 8'd14, 4'h1, 1'b0, 12'h7C0, 32'h0, 32'd6));
    idle(2);
    check("ill_flag", 32'(csr_illegal), 32'h1);
    check("ill_done", 32'(CSR_done), 32'h1);
    check("ill_old", CSR_result, 32'h0);

    // trap one cycle after issue kills the packet and records trap state
    issue(mk(8'd5, 8'd15, 4'h1, 1'b0, 12'h340, 32'h0, 32'd7));
    step(1'b0, mk(0, 0, 0, 0, 0, 0, 0), 1'b1, 32'h1234, 32'd2, 1'b0);
    idle(2);
    check("trap_mepc", csr_mepc, 32'h1234);
    issue(mk(8'd0, 8'd16, 4'h2, 1'b1, 12'h342, 32'h0, 32'd8));
    idle(2);
    check("trap_mcause", CSR_result, 32'd2);

    // mepc write colliding with a trap loses to the trap
    issue(mk(8'd5, 8'd17, 4'h1, 1'b0, 12'h341, 32'h0, 32'd9));
    idle(2);
    check("mepc_align", csr_mepc, 32'hDEAD_BEEC);
    issue(mk(8'd7, 8'd18, 4'h1, 1'b0, 12'h341, 32'h0, 32'd10));
    idle(1);
    step(1'b0, mk(0, 0, 0, 0, 0, 0, 0), 1'b1, 32'h1234, 32'd2, 1'b0);
    check("collide_mepc", csr_mepc, 32'h1234);
    check("collide_done", 32'(CSR_done), 32'h0);

    // mid-operation reset with S2 occupied
    issue(mk(8'd5, 8'd19, 4'h1, 1'b0, 12'h305, 32'h0, 32'd11));
    idle(2);
    issue(mk(8'd7, 8'd20, 4'h1, 1'b0, 12'h340, 32'h0, 32'd12));
    issue(mk(8'd7, 8'd21, 4'h1, 1'b0, 12'h300, 32'h0, 32'd13));
    idle(1);
    check("pre_rst_done", 32'(CSR_done), 32'h1);
    check("pre_rst_mtvec", csr_mtvec, 32'hDEAD_BEEF);
    #1 reset = 1'b0;
    #1;
    check("async_rst_done", 32'(CSR_done), 32'h0);
    check("async_rst_mtvec", csr_mtvec, 32'h0000_0100);
    model_reset();
    #1 reset = 1'b1;
    idle(4);
    check("post_rst_done", 32'(CSR_done), 32'h0);

    // random traffic with occasional traps and mrets
    for (int i = 0; i < 600; i++) begin
      pkt_t p;
      logic v, exc, mret;
      p = mk(8'($urandom), 8'($urandom), 4'($urandom_range(0, 4)), 1'($urandom),
             addrs[$urandom_range(0, 6)], $urandom, $urandom);
      v    = ($urandom_range(0, 9) < 8);
      exc  = ($urandom_range(0, 19) == 0);
      mret = ($urandom_range(0, 19) == 0);
      step(v, p, exc, $urandom, $urandom, mret);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_exec_unit.md
Name: csr_exec_unit

Overview:
- Execution stage directly downstream of the CSR reservation station.
- Consumes the 130-bit issue packet, reads the source physical register, and performs CSRRW/CSRRS/CSRRC and their immediate forms against an internal machine-mode CSR file.
- Broadcasts the old CSR value with CSR_done/CSR_phy, which feeds the wakeup logic of all reservation stations.
- Records trap state on exception_sig and exports mepc/mtvec to the fetch redirect logic.

Parameters:
- PHY_W, 8, physical register tag width
- XLEN, 32, data width
- MTVEC_RST, 32'h0000_0100, reset value of mtvec

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous active-low reset
- issue_pkt  input  130  issue packet from the CSR reservation station. Fields: [129] valid, [128:121] src phys tag, [120:89] inst_num, [88:81] Rd phys, [80:77] ALUOP, [76] ALUSrc2, [75:44] csr_data (ignored), [43:32] csr_addr, [31:0] immediate
- prf_raddr  output  8  physical register file read address
- prf_rdata  input  32  combinational PRF read data for prf_raddr
- exception_sig  input  1  trap taken this cycle
- exception_pc  input  32  PC of the trapping instruction
- exception_cause  input  32  trap cause code
- mret_sig  input  1  mret committed this cycle
- CSR_done  output  1  result valid pulse
- CSR_phy  output  8  destination physical tag
- CSR_result  output  32  old CSR value
- CSR_inst_num  output  32  instruction number of the result
- csr_illegal  output  1  pulse: access to an unimplemented CSR
- csr_mepc  output  32  current mepc
- csr_mtvec  output  32  current mtvec

Behaviour:
- Pipeline: S1 register, then S2 execute/writeback. A packet sampled valid at edge N produces CSR_done high for the single cycle following edge N+2. The block accepts one packet per cycle and has no backpressure.
- S1 holds the packet. prf_raddr = S1 src tag, combinationally from the S1 register. prf_rdata is latched into S2 at the next edge.
- Source operand: if ALUSrc2=1, use {27'b0, immediate[4:0]}; otherwise use the latched prf_rdata.
- ALUOP encoding:
  - 4'h1 = RW: new = src.
  - 4'h2 = RS: new = old | src.
  - 4'h3 = RC: new = old & ~src.
  - Any other code: no write. Result is still broadcast with CSR_result = old.
- RS/RC with src == 0 perform no write. Result is still produced.
- CSR file addresses:
  - 0x300 mstatus
  - 0x305 mtvec
  - 0x340 mscratch
  - 0x341 mepc (bits [1:0] forced 0 on write)
  - 0x342 mcause
- Unimplemented address: old = 0, no write, csr_illegal pulses together with CSR_done.
- CSR reads and writes both happen in S2, using the registered file. Back-to-back accesses to the same CSR therefore see the prior write with no extra forwarding.
- exception_sig:
  - Clears S1 and S2 valid at that edge; no CSR_done for in-flight packets.
  - Writes mepc <= exception_pc and mcause <= exception_cause.
  - If an S2 write to mepc/mcause coincides, the trap write wins.
- mret_sig: flushes S1 and S2 only; the CSR file is unchanged.
- If exception_sig and mret_sig are both high, exception_sig has priority.
- A packet arriving on a flush cycle is dropped.
- Reset values:
  - CSR_done=0, CSR_phy=0, CSR_result=0, CSR_inst_num=0, csr_illegal=0, prf_raddr=0.
  - mstatus=0, mtvec=MTVEC_RST, mscratch=0, mepc=0, mcause=0.
  - Pipeline valids = 0.
- Reset asserted mid-operation clears all state immediately, with no pulse on release.
- CSR_done, csr_illegal: single-cycle pulses, deasserted whenever S2 is not valid.

Optional Feature:
- CSR_COUNTERS_EN, when defined:
  - Adds mcycle (0xB00) and minstret (0xB02), 32-bit, reset 0.
  - mcycle increments every cycle; minstret increments on each CSR_done.
  - Both are writable via RW/RS/RC. A write takes priority over the increment in the same cycle.
- When not defined: 0xB00/0xB02 are unimplemented (read 0, csr_illegal).

Test Plan:
- RW: PRF[5]=32'hDEAD_BEEF, packet {src 5, Rd 9, ALUOP 1, addr 0x340} -> two cycles later CSR_done=1, CSR_phy=9, CSR_result=0; a following RS with imm 0 to 0x340 returns 32'hDEAD_BEEF.
- Back-to-back set then clear: RSI imm 5'h0F to 0x300, then RCI imm 5'h03 on the next cycle -> results 0 and 0x0F on consecutive cycles; mstatus ends at 0x0C.
- Illegal access: RW to 0x7C0 -> CSR_result=0, csr_illegal=1, CSR_done=1; no CSR changes.
- Exception flush: issue a packet, then assert exception_sig one cycle later with pc 0x1234, cause 2 -> no CSR_done; mepc=0x1234, mcause=2. RW mepc with 0x1237 colliding with the trap -> mepc=0x1234.
- Reset: assert reset low while S2 is valid -> CSR_done drops asynchronously; mtvec=0x100; no pulse after release.
